// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//   Final pipeline stage. Takes MEM/WB entries and commits register-file
//   writes and FFT sample writes into the FFT input buffer. When a full
//   frame has been buffered, it launches the FFT engine. While that frame
//   is being launched or transformed, further FFT samples are held back
//   with stall_out.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_in, fft_wr_en_in,
//   reg_wr_en_in, addr_in,
//   data_in                     MEM/WB pipe register contents
//   frame_reset                 discard the partial frame, return to FILL
//   fft_busy, fft_done          FFT engine handshake
//   stall_out                   combinational hold for upstream stages
//   rf_wr_*                     registered register-file write port
//   fft_buf_wr_*                registered FFT buffer write port
//   fft_start                   1-cycle start pulse to the FFT engine
//   frames_done                 completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATAW   = 16,
  parameter int ADDRW   = 32,
  parameter int REGW    = 4,
  parameter int FFT_PTS = 512,
  localparam int IDXW   = $clog2(FFT_PTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             fft_wr_en_in,
  input  logic             reg_wr_en_in,
  input  logic [ADDRW-1:0] addr_in,
  input  logic [DATAW-1:0] data_in,
  input  logic             frame_reset,
  input  logic             fft_busy,
  input  logic             fft_done,
  output logic             stall_out,
  output logic             rf_wr_en,
  output logic [REGW-1:0]  rf_wr_addr,
  output logic [DATAW-1:0] rf_wr_data,
  output logic             fft_buf_wr_en,
  output logic [IDXW-1:0]  fft_buf_wr_idx,
  output logic [DATAW-1:0] fft_buf_wr_data,
  output logic             fft_start,
  output logic [15:0]      frames_done
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } state_t;

  state_t          state_reg;
  logic [IDXW-1:0] idx_reg;

  logic accept;
  logic fft_accept;
  logic last_slot;

  // Only the register index part of the address is meaningful here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_in[ADDRW-1:REGW];

  // FFT samples are held back whenever the buffer is owned by the engine.
  // A frame_reset frees the buffer immediately, so it also lifts the stall
  // (the concurrent sample is then simply dropped).
  assign stall_out  = valid_in & fft_wr_en_in & (state_reg != ST_FILL) & ~frame_reset;
  assign accept     = valid_in & ~stall_out;
  assign fft_accept = accept & fft_wr_en_in & (state_reg == ST_FILL) & ~frame_reset;
  assign last_slot  = (idx_reg == IDXW'(FFT_PTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_FILL;
      idx_reg         <= '0;
      rf_wr_en        <= 1'b0;
      rf_wr_addr      <= '0;
      rf_wr_data      <= '0;
      fft_buf_wr_en   <= 1'b0;
      fft_buf_wr_idx  <= '0;
      fft_buf_wr_data <= '0;
      fft_start       <= 1'b0;
      frames_done     <= '0;
    end else begin
      // Strobes are single-cycle by default.
      rf_wr_en      <= 1'b0;
      fft_buf_wr_en <= 1'b0;
      fft_start     <= 1'b0;

      // Register writes are independent of the frame state machine and
      // still commit alongside a frame_reset.
      if (accept && reg_wr_en_in) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= addr_in[REGW-1:0];
        rf_wr_data <= data_in;
      end

      if (frame_reset) begin
        state_reg <= ST_FILL;
        idx_reg   <= '0;
      end else begin
        unique case (state_reg)
          ST_FILL: begin
            if (fft_accept) begin
              fft_buf_wr_en   <= 1'b1;
              fft_buf_wr_idx  <= idx_reg;
              fft_buf_wr_data <= data_in;
              if (last_slot) begin
                idx_reg   <= '0;
                state_reg <= ST_LAUNCH;
              end else begin
                idx_reg <= idx_reg + IDXW'(1);
              end
            end
          end
          ST_LAUNCH: begin
            // Entered on the edge that registers the final sample write,
            // so the start pulse always trails that write by a cycle.
            if (!fft_busy) begin
              fft_start <= 1'b1;
              state_reg <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (fft_done) begin
              state_reg   <= ST_FILL;
              frames_done <= frames_done + 16'd1;
            end
          end
          default: begin
            state_reg <= ST_FILL;
            idx_reg   <= '0;
          end
        endcase
      end
    end
  end

endmodule
